// File: rtl/csr_uart_rx.sv
// 8N1 UART receiver behind a single CSR: bytes queue in a small FIFO, read pops the head.
// Status word carries not-empty plus sticky overrun/framing flags that software clears by writing ones.
module csr_uart_rx #(
  parameter int          CLOCK_RATE = 200_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [11:0] CSR_ADDR   = 12'hBC3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx
);

  localparam int            P      = CLOCK_RATE / BAUD_RATE;
  localparam int            CW     = $clog2(P + 1);
  localparam logic [CW-1:0] P_LAST = CW'(P - 1);
  localparam logic [CW-1:0] H_LAST = CW'(P / 2 - 1);
  localparam int            AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic            rx_s1_q, rx_s2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            brk_q, brk_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic hit, wr_hit, empty, full, pop, push, push_ok, ovr_set, ferr_set;
  logic [7:0] head;
  logic unused_wdata;

  assign unused_wdata = ^{wdata[31:11], wdata[8:0]};

  assign hit    = (addr == CSR_ADDR) & (read | (modify != 3'd0));
  assign wr_hit = hit & (modify != 3'd0);
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH);
  assign pop    = hit & read & ~empty;
  assign head   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign valid  = hit;
  assign rdata  = hit ? {21'b0, ferr_q, ovr_q, ~empty, head} : 32'b0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    brk_d    = brk_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s2_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          // A start bit that is high again at mid-bit was only a glitch
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == P_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (brk_q) begin
          // Hold off after a framing error until the line is idle again
          if (rx_s2_q) begin
            brk_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (cnt_q == P_LAST) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            brk_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    push_ok  = push & (~full | pop);
    ovr_set  = push & full & ~pop;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovr_d  = ovr_set  | (ovr_q  & ~(wr_hit & wdata[9]));
    ferr_d = ferr_set | (ferr_q & ~(wr_hit & wdata[10]));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      brk_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      brk_q    <= brk_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end
  end

endmodule

// File: doc/csr_uart_rx.md
CSR_UART_RX -- requirements
Module: csr_uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 200_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, 2..256).
REQ-004 SHALL have parameter CSR_ADDR, default 12'hBC3, meaning the CSR address decoded by this block.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL have port read  input  1  CSR read request from pipeline.
REQ-008 SHALL have port modify  input  3  CSR write operation; 0 = no write, nonzero = write.
REQ-009 SHALL have port wdata  input  32  CSR write data.
REQ-010 SHALL have port addr  input  12  CSR address.
REQ-011 SHALL have port rdata  output  32  CSR read data.
REQ-012 SHALL have port valid  output  1  address hit: this block responds.
REQ-013 SHALL have port rx  input  1  asynchronous serial input, idle high, 8N1.

Function
REQ-014 SHALL define hit = (addr == CSR_ADDR) & (read | modify != 0); valid = hit, combinational, same cycle.
REQ-015 SHALL drive rdata = 0 when hit = 0; otherwise rdata[7:0] = FIFO head byte (0 if empty), [8] = not-empty, [9] = overrun sticky, [10] = framing-error sticky, [31:11] = 0.
REQ-016 SHALL pop the FIFO head at the clock edge ending a cycle with hit & read & not-empty; read on empty FIFO pops nothing.
REQ-017 SHALL clear overrun if wdata[9] = 1 and framing-error if wdata[10] = 1 at the edge ending a cycle with hit & modify != 0; other wdata bits ignored.
REQ-018 SHALL synchronise rx through two flip-flops (reset value 1) before any use.
REQ-019 SHALL use bit period P = CLOCK_RATE / BAUD_RATE clocks (integer division) and half period P/2.
REQ-020 SHALL implement FSM IDLE, START, DATA, STOP: IDLE -> START on synchronised rx = 0; START waits P/2, then -> DATA if rx = 0, else -> IDLE (glitch rejected).
REQ-021 SHALL in DATA sample rx every P clocks, 8 samples, LSB first, then -> STOP.
REQ-022 SHALL in STOP sample rx after P clocks: 1 -> push byte, -> IDLE; 0 -> discard byte, set framing-error sticky, -> IDLE only after rx returns to 1.
REQ-023 SHALL on push with FIFO full and no pop in the same cycle discard the new byte and set overrun sticky; FIFO contents unchanged.
REQ-024 SHALL on simultaneous push and pop with FIFO full perform both, no overrun; on simultaneous push and pop-attempt with FIFO empty store the byte, pop ignored.
REQ-025 SHALL let a set event win over a clear event to the same sticky bit in the same cycle.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and hold FIFO_DEPTH bytes exactly before reporting full.
REQ-027 SHALL write no state on a hit with read = 0 and modify = 0 (impossible per REQ-014) or on any non-hit access.

Reset
REQ-028 SHALL on rstn = 0 immediately, regardless of clk: FSM -> IDLE, counters 0, FIFO empty, pointers 0, both sticky bits 0, synchroniser 1.
REQ-029 SHALL drop any partially received byte when reset asserts mid-frame; after release, reception restarts only on a new falling edge.
REQ-030 SHALL hold valid = 0 and rdata = 0 while no access is presented, including during and after reset.

Verification (CLOCK_RATE = 1_000_000, BAUD_RATE = 100_000, P = 10, FIFO_DEPTH = 4)
REQ-031 SHALL test: send frame 0xA5, then read at BC3h -> rdata = 0x000001A5, valid = 1; next read -> rdata = 0x00000000.
REQ-032 SHALL test: rx low pulse of 3 clocks -> no byte, no error; read -> rdata = 0x00000000.
REQ-033 SHALL test: send 5 bytes 0x01..0x05 without reading -> reads return 0x101, 0x102, 0x103, 0x104 with bit 9 set, then empty with bit 9 set; write wdata = 0x200 -> bit 9 = 0.
REQ-034 SHALL test: frame 0x3C with stop bit 0 -> FIFO empty, read -> rdata = 0x00000400; write wdata = 0x400 clears it.
REQ-035 SHALL test: access with addr = BC0h -> valid = 0, rdata = 0, FIFO not popped.
REQ-036 SHALL test: rstn pulsed low during DATA of frame 0x55, then full frame 0x66 -> only 0x66 received, no error bits.
